mem_unit: RTL and testbench
===========================

Name: mem_unit

Overview:
- Word-addressed instruction/data memory sitting directly downstream of the CPU datapath.
- Consumes the datapath's MAR, MDR write data and Read/Write strobes.
- Returns read data on OUT_MDR for the datapath's MDR input mux.
- Multi-cycle FSM with configurable wait states and a single-pulse ready handshake, so the control unit can stall until completion.

Parameters:
- ADDR_BITS, 9, number of implemented word-address bits; depth = 2**ADDR_BITS words of 32 bits.
- WAIT_STATES, 1, extra cycles inserted between request capture and array access; legal range 0..15.
- WP_LIMIT, 32'd16, with MEM_WP_EN: addresses strictly below this value are write-protected.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- Read  input  1  read request, level, held by the requester until mem_ready.
- Write  input  1  write request, level, held by the requester until mem_ready.
- MAR  input  32  word address from the datapath MAR.
- MDR  input  32  write data from the datapath MDR.
- OUT_MDR  output  32  read data to the datapath MDR mux.
- mem_ready  output  1  one-cycle completion pulse.
- mem_busy  output  1  high while a request is in flight (state other than IDLE).
- addr_err  output  1  one-cycle fault pulse, coincident with mem_ready.

Behaviour:
- reset low (asynchronous):
  - State goes to IDLE.
  - OUT_MDR = 0, mem_ready = 0, mem_busy = 0, addr_err = 0, wait counter = 0.
  - Array contents are NOT cleared.
- States: IDLE, WAIT, ACCESS, DONE.
- IDLE:
  - On the first edge with Read or Write high, latch MAR, MDR and the operation.
  - Go to WAIT if WAIT_STATES > 0, else to ACCESS.
- WAIT: count down WAIT_STATES cycles, then go to ACCESS.
- ACCESS:
  - Read: OUT_MDR <= array[addr].
  - Write: array[addr] <= latched data.
  - Then go to DONE.
- DONE:
  - mem_ready = 1 for exactly one cycle; addr_err valid this cycle.
  - Return to IDLE.
- Latency: request seen at edge N -> mem_ready high in cycle N + WAIT_STATES + 2.
- Back-to-back: if the request is still high in the cycle after DONE, it is treated as a new request. Requester must drop Read/Write in the mem_ready cycle.
- OUT_MDR holds its last read value until the next completed read. Writes never change OUT_MDR.
- Out of range (MAR[31:ADDR_BITS] != 0):
  - No array access.
  - A read loads OUT_MDR = 0.
  - addr_err pulses with mem_ready.
- Read and Write both high at capture:
  - Command fault; no access; OUT_MDR unchanged.
  - addr_err pulses with mem_ready after normal latency.
- Changes to MAR/MDR after capture are ignored until DONE.
- Requests dropped mid-operation are still completed (no abort).
- Reset asserted mid-operation:
  - Aborts to IDLE.
  - A write whose ACCESS edge had not occurred is not performed.
- Array: inferred synchronous single-port RAM, one access per cycle (ACCESS only).

Optional Feature:
- Macro MEM_WP_EN.
- Defined:
  - A write to an in-range address < WP_LIMIT is suppressed; the array is unchanged.
  - addr_err pulses with mem_ready; latency unchanged.
  - Reads of protected addresses behave normally.
- Undefined: WP_LIMIT is ignored and every in-range address is writable.

Test Plan:
- Reset with WAIT_STATES=1: hold reset low, then release -> OUT_MDR=0, mem_ready=0, mem_busy=0. Assert reset mid-WAIT of a write to 0x20 -> returns to IDLE; a later read of 0x20 returns its prior value.
- Write then read, WAIT_STATES=1: Write MAR=0x05 MDR=0xDEADBEEF -> mem_ready 3 cycles after capture, addr_err=0. Read MAR=0x05 -> OUT_MDR=0xDEADBEEF with mem_ready 3 cycles later; mem_busy high for the 3 intervening cycles.
- Zero wait states (WAIT_STATES=0): Read MAR=0x1FF after writing 0x12345678 -> mem_ready 2 cycles after capture with OUT_MDR=0x12345678.
- Faults:
  - Read MAR=0x200 (ADDR_BITS=9) -> OUT_MDR=0, addr_err=1 with mem_ready.
  - Read=Write=1 at MAR=0x05 -> addr_err=1; 0x05 still reads 0xDEADBEEF.
- Held request: keep Read high one cycle past mem_ready -> a second access starts and mem_ready pulses again after latency. Changing MAR mid-WAIT from 0x05 to 0x06 -> data from 0x05 returned.
- With MEM_WP_EN, WP_LIMIT=16:
  - Write 0xCAFEF00D to 0x03 -> addr_err=1; 0x03 unchanged.
  - Same write to 0x10 -> succeeds, addr_err=0.
  - Without the macro -> the write to 0x03 succeeds.

Source files
------------

// File: rtl/mem_unit_if.sv
// mem_unit_if - request/response bundle between the CPU datapath and mem_unit.
//   master : datapath side, drives Read/Write/MAR/MDR, receives completion.
//   slave  : memory side, receives the request, drives OUT_MDR and status.
// Signals:
//   Read, Write     level requests, held until mem_ready
//   MAR [31:0]      word address
//   MDR [31:0]      write data
//   OUT_MDR [31:0]  read data
//   mem_ready       one-cycle completion pulse
//   mem_busy        request in flight
//   addr_err        one-cycle fault pulse, coincident with mem_ready
interface mem_unit_if;
  logic        Read;
  logic        Write;
  logic [31:0] MAR;
  logic [31:0] MDR;
  logic [31:0] OUT_MDR;
  logic        mem_ready;
  logic        mem_busy;
  logic        addr_err;

  modport master (
    output Read, Write, MAR, MDR,
    input  OUT_MDR, mem_ready, mem_busy, addr_err
  );

  modport slave (
    input  Read, Write, MAR, MDR,
    output OUT_MDR, mem_ready, mem_busy, addr_err
  );
endinterface

// File: rtl/mem_unit.sv
// mem_unit - word-addressed 32-bit memory with wait states and a ready pulse.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous active-low reset
//   bus    mem_unit_if.slave (Read/Write/MAR/MDR in, OUT_MDR/mem_ready/
//          mem_busy/addr_err out)
// Parameters:
//   ADDR_BITS    implemented word-address bits (depth 2**ADDR_BITS)
//   WAIT_STATES  extra cycles between capture and array access (0..15)
//   WP_LIMIT     write-protect bound, used only when MEM_WP_EN is defined
// Build option:
//   MEM_WP_EN    when defined, writes to in-range addresses below WP_LIMIT
//                are suppressed and flagged on addr_err.
//
// state  | meaning
// IDLE   | waiting for Read/Write; captures request on first edge seen
// WAIT   | burning WAIT_STATES cycles on a down-counter
// ACCESS | single array access (read into OUT_MDR or write)
// DONE   | mem_ready (and addr_err if faulted) high for this cycle
module mem_unit #(
  parameter int          ADDR_BITS   = 9,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] WP_LIMIT    = 32'd16
) (
  input logic       clk,
  input logic       reset,
  mem_unit_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_BITS;
  // Counter is loaded with WAIT_STATES-1 so terminal count 0 ends WAIT.
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS,
    ST_DONE
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [3:0]           wait_cnt;
  logic [ADDR_BITS-1:0] addr_q;
  logic [31:0]          data_q;
  logic                 rd_q;
  logic                 wr_q;
  logic                 oor_q;
  logic                 err_q;
  logic [31:0]          out_mdr;
  logic [31:0]          mem [DEPTH];

  logic capture;
  logic req_oor;
  logic req_both;
  logic wp_hit;

  assign capture  = (state == ST_IDLE) && (bus.Read || bus.Write);
  assign req_oor  = |bus.MAR[31:ADDR_BITS];
  assign req_both = bus.Read && bus.Write;

`ifdef MEM_WP_EN
  assign wp_hit = bus.Write && !bus.Read && !req_oor && (bus.MAR < WP_LIMIT);
`else
  logic wp_limit_unused;
  assign wp_limit_unused = |WP_LIMIT;
  assign wp_hit          = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (capture) state_nxt = (WAIT_STATES > 0) ? ST_WAIT : ST_ACCESS;
      end
      ST_WAIT: begin
        if (wait_cnt == 4'd0) state_nxt = ST_ACCESS;
      end
      ST_ACCESS: state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Request latch, wait counter and read-data register.
  // rd_q/wr_q are exclusive: a Read+Write command leaves both clear so the
  // access state does nothing and only err_q reports the fault.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= 4'd0;
      addr_q   <= '0;
      data_q   <= 32'd0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      oor_q    <= 1'b0;
      err_q    <= 1'b0;
      out_mdr  <= 32'd0;
    end else begin
      if (capture) begin
        wait_cnt <= WAIT_LOAD;
        addr_q   <= bus.MAR[ADDR_BITS-1:0];
        data_q   <= bus.MDR;
        rd_q     <= bus.Read && !bus.Write;
        wr_q     <= bus.Write && !bus.Read;
        oor_q    <= req_oor;
        err_q    <= req_oor || req_both || wp_hit;
      end else if (state == ST_WAIT && wait_cnt != 4'd0) begin
        wait_cnt <= wait_cnt - 4'd1;
      end

      if (state == ST_ACCESS && rd_q) begin
        out_mdr <= oor_q ? 32'd0 : mem[addr_q];
      end
    end
  end

  // Array write port; no reset so the contents survive reset. Any fault
  // (range or write-protect) suppresses the write.
  always_ff @(posedge clk) begin
    if (state == ST_ACCESS && wr_q && !err_q) begin
      mem[addr_q] <= data_q;
    end
  end

  assign bus.OUT_MDR   = out_mdr;
  assign bus.mem_ready = (state == ST_DONE);
  assign bus.mem_busy  = (state != ST_IDLE);
  assign bus.addr_err  = (state == ST_DONE) && err_q;

endmodule

// File: tb/tb_mem_unit.sv
// tb_mem_unit - directed plus randomized checks of mem_unit against a
// word-level reference model. Two instances: WAIT_STATES=1 (sel 1) and
// WAIT_STATES=0 (sel 0), sharing clock and reset.
module tb_mem_unit;

  localparam int AB = 9;
`ifdef MEM_WP_EN
  localparam bit WP_ON = 1'b1;
`else
  localparam bit WP_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_unit_if bus1();
  mem_unit_if bus0();

  mem_unit #(.ADDR_BITS(AB), .WAIT_STATES(1), .WP_LIMIT(32'd16)) dut1 (
    .clk(clk), .reset(rst_n), .bus(bus1)
  );
  mem_unit #(.ADDR_BITS(AB), .WAIT_STATES(0), .WP_LIMIT(32'd16)) dut0 (
    .clk(clk), .reset(rst_n), .bus(bus0)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: key = sel*1024 + word address (in-range only).
  logic [31:0] ref_mem [int];
  logic [31:0] ref_out [2];
  bit          out_known [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input bit rd, input bit wr,
                       input logic [31:0] a, input logic [31:0] d);
    if (sel == 1) begin
      bus1.Read = rd; bus1.Write = wr; bus1.MAR = a; bus1.MDR = d;
    end else begin
      bus0.Read = rd; bus0.Write = wr; bus0.MAR = a; bus0.MDR = d;
    end
  endtask

  task automatic sample(input int sel, output logic rdy, output logic busy,
                        output logic err, output logic [31:0] out);
    if (sel == 1) begin
      rdy = bus1.mem_ready; busy = bus1.mem_busy; err = bus1.addr_err; out = bus1.OUT_MDR;
    end else begin
      rdy = bus0.mem_ready; busy = bus0.mem_busy; err = bus0.addr_err; out = bus0.OUT_MDR;
    end
  endtask

  // Waits for mem_ready after a capture edge; optionally re-drives the request
  // in the first cycle after capture (address change or early drop).
  task automatic finish_op(input int sel, input string tag, input bit exp_err,
                           input logic [31:0] exp_out, input bit out_chk,
                           input bit bump, input bit b_rd, input bit b_wr,
                           input logic [31:0] b_a, input logic [31:0] b_d);
    int cycles = 0;
    bit got = 0;
    bit busy_all = 1;
    logic rdy, busy, err;
    logic [31:0] out;
    int ws = (sel == 1) ? 1 : 0;
    rdy = 0; busy = 0; err = 0; out = 0;
    while (!got && cycles < 40) begin
      @(negedge clk);
      cycles++;
      sample(sel, rdy, busy, err, out);
      busy_all = busy_all & (busy === 1'b1);
      if (rdy === 1'b1) got = 1;
      if (bump && cycles == 1) drive(sel, b_rd, b_wr, b_a, b_d);
    end
    check({tag, " latency"}, 32'(cycles), 32'(ws + 2));
    check({tag, " busy"}, 32'(busy_all), 32'd1);
    check({tag, " addr_err"}, 32'(err), 32'(exp_err));
    if (out_chk) check({tag, " OUT_MDR"}, out, exp_out);
  endtask

  task automatic do_op(input int sel, input bit rd, input bit wr,
                       input logic [31:0] a, input logic [31:0] d,
                       input bit hold, input bit bump, input logic [31:0] bump_a,
                       input string tag);
    bit oor = (a >= (32'd1 << AB));
    bit err = (rd && wr) || oor || (WP_ON && wr && !rd && !oor && a < 32'd16);
    int key = sel * 1024 + int'(a[AB-1:0]);
    logic [31:0] eo = ref_out[sel];
    bit ek = out_known[sel];
    logic rdy, busy, e2;
    logic [31:0] out;
    if (rd && !wr) begin
      if (oor) begin
        eo = 32'd0; ek = 1;
      end else if (ref_mem.exists(key)) begin
        eo = ref_mem[key]; ek = 1;
      end else begin
        ek = 0;
      end
    end
    @(negedge clk);
    drive(sel, rd, wr, a, d);
    finish_op(sel, tag, err, eo, ek, bump, rd, wr, bump_a, ~d);
    if (!hold) drive(sel, 1'b0, 1'b0, 32'd0, 32'd0);
    if (wr && !rd && !err) ref_mem[key] = d;
    ref_out[sel]   = eo;
    out_known[sel] = ek;
    @(negedge clk);
    sample(sel, rdy, busy, e2, out);
    check({tag, " ready pulse"}, 32'(rdy), 32'd0);
    check({tag, " idle busy"}, 32'(busy), 32'd0);
  endtask

  logic        s_rdy, s_busy, s_err;
  logic [31:0] s_out;

  initial begin
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    ref_out[0] = 0; ref_out[1] = 0;
    out_known[0] = 1; out_known[1] = 1;

    // Reset state, during and after reset.
    repeat (3) @(negedge clk);
    sample(1, s_rdy, s_busy, s_err, s_out);
    check("rst OUT_MDR", s_out, 32'd0);
    check("rst mem_ready", 32'(s_rdy), 32'd0);
    check("rst mem_busy", 32'(s_busy), 32'd0);
    check("rst addr_err", 32'(s_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    sample(0, s_rdy, s_busy, s_err, s_out);
    check("post-rst OUT_MDR", s_out, 32'd0);
    check("post-rst mem_busy", 32'(s_busy), 32'd0);

    // Write then read with one wait state.
    do_op(1, 0, 1, 32'h05, 32'hDEADBEEF, 0, 0, 0, "wr05");
    do_op(1, 1, 0, 32'h05, 32'h0, 0, 0, 0, "rd05");

    // Zero wait states at the top address.
    do_op(0, 0, 1, 32'h1FF, 32'h12345678, 0, 0, 0, "ws0 wr1ff");
    do_op(0, 1, 0, 32'h1FF, 32'h0, 0, 0, 0, "ws0 rd1ff");

    // Faults.
    do_op(1, 1, 0, 32'h200, 32'h0, 0, 0, 0, "rd oor");
    do_op(1, 1, 0, 32'h05, 32'h0, 0, 0, 0, "rd05 again");
    do_op(1, 1, 1, 32'h05, 32'h11111111, 0, 0, 0, "cmd fault");
    do_op(1, 0, 1, 32'h8000_0005, 32'h22222222, 0, 0, 0, "wr oor");
    do_op(1, 1, 0, 32'h05, 32'h0, 0, 0, 0, "rd05 after faults");

    // Held request: second access, dropped mid-operation, still completes.
    do_op(1, 0, 1, 32'h06, 32'h66666666, 0, 0, 0, "wr06");
    do_op(1, 1, 0, 32'h05, 32'h0, 1, 0, 0, "held1");
    finish_op(1, "held2", 1'b0, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);

    // MAR changed mid-WAIT is ignored.
    do_op(1, 1, 0, 32'h05, 32'h0, 0, 1, 32'h06, "mar change");

    // Write-protect boundary (active only with MEM_WP_EN).
    do_op(1, 0, 1, 32'h03, 32'hCAFEF00D, 0, 0, 0, "wr03");
    do_op(1, 0, 1, 32'h10, 32'hCAFEF00D, 0, 0, 0, "wr10");
    do_op(1, 1, 0, 32'h10, 32'h0, 0, 0, 0, "rd10");
    if (!WP_ON) do_op(1, 1, 0, 32'h03, 32'h0, 0, 0, 0, "rd03");

    // Reset mid-WAIT of a write to 0x20 aborts the write.
    do_op(1, 0, 1, 32'h20, 32'hA5A5_0020, 0, 0, 0, "wr20");
    @(negedge clk);
    drive(1, 0, 1, 32'h20, 32'h5A5A_FFFF);
    @(negedge clk);
    sample(1, s_rdy, s_busy, s_err, s_out);
    check("mid-wait busy", 32'(s_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    sample(1, s_rdy, s_busy, s_err, s_out);
    check("abort busy", 32'(s_busy), 32'd0);
    check("abort ready", 32'(s_rdy), 32'd0);
    check("abort OUT_MDR", s_out, 32'd0);
    drive(1, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ref_out[0] = 0; ref_out[1] = 0;
    out_known[0] = 1; out_known[1] = 1;
    do_op(1, 1, 0, 32'h20, 32'h0, 0, 0, 0, "rd20 after abort");

    // Randomized traffic against the model.
    for (int i = 0; i < 45; i++) begin
      int sel;
      int k;
      int m;
      bit rd;
      bit wr;
      logic [31:0] a;
      sel = (i % 3 == 0) ? 0 : 1;
      k = $urandom_range(0, 9);
      m = $urandom_range(0, 7);
      rd = (k < 4) || (k >= 8);
      wr = (k >= 4);
      if (m == 0)      a = 32'h200 + 32'($urandom_range(0, 255));
      else if (m == 1) a = $urandom | 32'h8000_0000;
      else if (m == 2) a = 32'h1E0 | 32'($urandom_range(0, 31));
      else             a = 32'($urandom_range(0, 31));
      do_op(sel, rd, wr, a, $urandom, 0, 0, 0, $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
